// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM state encodings and a few small op-classification helpers.
package hilo_pkg;

  localparam int WIDTH_DEF = 32;

  // EX op encodings for HI/LO-writing instructions
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // Engine FSM state encodings
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MUL  = 2'd1;
  localparam state_t ST_DIV  = 2'd2;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/radix2_divider.sv
// Unsigned iterative restoring divider, one quotient bit per cycle.
// A start loads the operands; the last iteration's result is presented
// combinationally together with valid, so the owner commits it on the
// edge that ends the WIDTH-th busy cycle.
module radix2_divider
  import hilo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             kill,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid
);

  logic             active;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_p0;
  logic [WIDTH-1:0] quo_p0;
  logic [WIDTH-1:0] dvs_p0;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  // One restoring step: shift in the next dividend bit, trial-subtract,
  // keep the difference only when it did not borrow.
  always_comb begin
    rem_sh  = {rem_p0, quo_p0[WIDTH-1]};
    diff    = rem_sh - {1'b0, dvs_p0};
    rem_nxt = diff[WIDTH-1:0];
    quo_nxt = {quo_p0[WIDTH-2:0], 1'b1};
    if (diff[WIDTH]) begin
      rem_nxt = rem_sh[WIDTH-1:0];
      quo_nxt = {quo_p0[WIDTH-2:0], 1'b0};
    end
  end

  assign quotient  = quo_nxt;
  assign remainder = rem_nxt;
  assign valid     = active && (cnt == CNT_W'(1));

  // Iteration control: counts WIDTH steps, kill abandons the division
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (kill) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= CNT_W'(WIDTH);
    end else if (active) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) active <= 1'b0;
    end
  end

  // Partial remainder / quotient shift register (datapath, no reset)
  always_ff @(posedge clk) begin
    if (start) begin
      rem_p0 <= '0;
      quo_p0 <= dividend;
      dvs_p0 <= divisor;
    end else if (active) begin
      rem_p0 <= rem_nxt;
      quo_p0 <= quo_nxt;
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Architectural HI/LO registers with a multi-cycle multiply/divide engine.
// Forwards MTHI/MTLO being accepted in EX to MFHI/MFLO reads in ID and
// raises stall_req while a multiply or divide result is still pending.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int MUL_LAT = 2,
  parameter int CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [2:0]       ex_op,
  input  logic [WIDTH-1:0] ex_rs,
  input  logic [WIDTH-1:0] ex_rt,
  input  logic             ex_flush,
  input  logic             id_rd_req,
  input  logic             id_rd_sel,
  output logic [WIDTH-1:0] id_rd_data,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q
);

  localparam int MCNT_W = $clog2(MUL_LAT + 1);

  // Full-width product; zero/sign extension to 2*WIDTH makes the truncated
  // unsigned product correct for both signed and unsigned operands.
  function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic             sgn);
    logic [2*WIDTH-1:0] ea;
    logic [2*WIDTH-1:0] eb;
    ea = {{WIDTH{sgn & a[WIDTH-1]}}, a};
    eb = {{WIDTH{sgn & b[WIDTH-1]}}, b};
    return ea * eb;
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             sgn);
    return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  state_t             state;
  logic [MCNT_W-1:0]  mul_cnt;
  logic               dz_p0;
  logic [WIDTH-1:0]   dz_rs_p0;
  logic               q_neg_p0;
  logic               r_neg_p0;
  logic [2*WIDTH-1:0] prod_p [MUL_LAT];

  logic             accept;
  logic             acc_mul;
  logic             acc_div;
  logic             acc_mthi;
  logic             acc_mtlo;
  logic             div_zero_in;
  logic             div_signed;
  logic             div_start;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  logic             div_valid;
  logic             mul_commit;
  logic             div_commit;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  assign busy        = (state != ST_IDLE);
  assign accept      = ex_valid && !busy && !ex_flush;
  assign acc_mul     = accept && is_mul_op(ex_op);
  assign acc_div     = accept && is_div_op(ex_op);
  assign acc_mthi    = accept && (ex_op == OP_MTHI);
  assign acc_mtlo    = accept && (ex_op == OP_MTLO);
  assign div_zero_in = (ex_rt == '0);
  assign div_signed  = (ex_op == OP_DIV);
  assign div_start   = acc_div && !div_zero_in;
  assign stall_req   = (ex_valid && busy) || (id_rd_req && busy);

  assign mul_commit = (state == ST_MUL) && (mul_cnt == '0) && !ex_flush;
  assign div_commit = (state == ST_DIV) && (dz_p0 || div_valid) && !ex_flush;

  // Divide-by-zero bypasses the core and returns dividend / all-ones
  assign div_hi = dz_p0 ? dz_rs_p0 : apply_sign(div_rem, r_neg_p0);
  assign div_lo = dz_p0 ? '1       : apply_sign(div_quo, q_neg_p0);

  radix2_divider #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (magnitude(ex_rs, div_signed)),
    .divisor   (magnitude(ex_rt, div_signed)),
    .kill      (ex_flush),
    .quotient  (div_quo),
    .remainder (div_rem),
    .valid     (div_valid)
  );

  // Forwarding mux: an MTHI/MTLO accepted this cycle beats the register
  always_comb begin
    id_rd_data = id_rd_sel ? lo_q : hi_q;
    if ((acc_mthi && !id_rd_sel) || (acc_mtlo && id_rd_sel)) id_rd_data = ex_rs;
  end

  // Stage p0..p(MUL_LAT-1): product delay chain
  always_ff @(posedge clk) begin
    prod_p[0] <= mul_full(ex_rs, ex_rt, ex_op == OP_MULT);
    for (int i = 1; i < MUL_LAT; i++) prod_p[i] <= prod_p[i-1];
  end

  // Stage p0: divide sign fix-up and divide-by-zero operand capture
  always_ff @(posedge clk) begin
    if (acc_div) begin
      q_neg_p0 <= div_signed && (ex_rs[WIDTH-1] ^ ex_rt[WIDTH-1]);
      r_neg_p0 <= div_signed && ex_rs[WIDTH-1];
      dz_rs_p0 <= ex_rs;
    end
  end

  // Engine FSM and the registered done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      mul_cnt <= '0;
      dz_p0   <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= mul_commit || div_commit;
      case (state)
        ST_IDLE: begin
          if (acc_mul) begin
            state   <= ST_MUL;
            mul_cnt <= MCNT_W'(MUL_LAT - 1);
          end else if (acc_div) begin
            state <= ST_DIV;
            dz_p0 <= div_zero_in;
          end
        end
        ST_MUL: begin
          if (ex_flush || (mul_cnt == '0)) begin
            state   <= ST_IDLE;
            mul_cnt <= '0;
          end else begin
            mul_cnt <= mul_cnt - MCNT_W'(1);
          end
        end
        ST_DIV: begin
          if (ex_flush || dz_p0 || div_valid) begin
            state <= ST_IDLE;
            dz_p0 <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Architectural HI/LO update from MTHI/MTLO or a mul/div commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (acc_mthi) hi_q <= ex_rs;
      if (acc_mtlo) lo_q <= ex_rs;
      if (mul_commit) {hi_q, lo_q} <= prod_p[MUL_LAT-1];
      if (div_commit) begin
        hi_q <= div_hi;
        lo_q <= div_lo;
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: scoreboard of expected HI/LO
// results checked on every done pulse, plus per-scenario inline checks.
module tb_hilo_muldiv_unit;
  import hilo_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [31:0] ex_rs;
  logic [31:0] ex_rt;
  logic        ex_flush;
  logic        id_rd_req;
  logic        id_rd_sel;
  logic [31:0] id_rd_data;
  logic        busy;
  logic        stall_req;
  logic        done;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] scoreboard[$];

  hilo_muldiv_unit #(.WIDTH(32), .MUL_LAT(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_op      (ex_op),
    .ex_rs      (ex_rs),
    .ex_rt      (ex_rt),
    .ex_flush   (ex_flush),
    .id_rd_req  (id_rd_req),
    .id_rd_sel  (id_rd_sel),
    .id_rd_data (id_rd_data),
    .busy       (busy),
    .stall_req  (stall_req),
    .done       (done),
    .hi_q       (hi_q),
    .lo_q       (lo_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: {HI, LO} for a mul/div op
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] r;
    longint pa, pb;
    int sa, sdv;
    r = '0;
    case (op)
      OP_MULT: begin
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        r  = pa * pb;
      end
      OP_MULTU: r = {32'h0, a} * {32'h0, b};
      OP_DIVU: begin
        if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
        else            r = {a % b, a / b};
      end
      OP_DIV: begin
        sa  = a;
        sdv = b;
        if (b == 32'h0)                                   r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else                                              r = {32'(sa % sdv), 32'(sa / sdv)};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] b);
    if (is_mul_op(op)) return 2;
    return (b == 32'h0) ? 1 : 32;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op for one cycle; push its expected result when it should commit
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_commit);
    ex_valid = 1'b1;
    ex_op    = op;
    ex_rs    = a;
    ex_rt    = b;
    if (expect_commit) scoreboard.push_back(model(op, a, b));
    tick();
    ex_valid = 1'b0;
  endtask

  // Bounded wait for done; lat counts cycles from the accepting edge
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_checks++;
      if (scoreboard.size() == 0) begin
        $display("FAIL sb_unexpected_done: got done with hi=%h lo=%h, required no done", hi_q, lo_q);
      end else begin
        logic [63:0] exp;
        exp = scoreboard.pop_front();
        if ({hi_q, lo_q} !== exp)
          $display("FAIL sb_result: got %h_%h required %h_%h", hi_q, lo_q, exp[63:32], exp[31:0]);
        else n_pass++;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b1; ex_valid = 0; ex_op = 0; ex_rs = 0; ex_rt = 0; ex_flush = 0;
    id_rd_req = 1'b1; id_rd_sel = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (id_rd_data !== 32'h0) $display("FAIL rst_mfhi: got %h required 0", id_rd_data); else n_pass++;
    n_checks++; if (stall_req !== 1'b0) $display("FAIL rst_stall: got %b required 0", stall_req); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b required 0", done); else n_pass++;
    id_rd_sel = 1'b1;
    #1;
    n_checks++; if (id_rd_data !== 32'h0) $display("FAIL rst_mflo: got %h required 0", id_rd_data); else n_pass++;
    tick();
    rst_n = 1'b1;
    id_rd_req = 1'b0;
    tick();
  endtask

  task automatic test_mtxx_forward();
    ex_valid = 1'b1; ex_op = OP_MTHI; ex_rs = 32'h1234_5678;
    id_rd_req = 1'b1; id_rd_sel = 1'b0;
    #1;
    n_checks++; if (id_rd_data !== 32'h1234_5678) $display("FAIL fwd_mthi: got %h required 12345678", id_rd_data); else n_pass++;
    n_checks++; if (stall_req !== 1'b0) $display("FAIL fwd_mthi_stall: got %b required 0", stall_req); else n_pass++;
    tick();
    ex_valid = 1'b0;
    n_checks++; if (hi_q !== 32'h1234_5678) $display("FAIL mthi_hi: got %h required 12345678", hi_q); else n_pass++;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL mthi_busy_done: got %b%b required 00", busy, done); else n_pass++;
    // MTLO with a HI read: the mismatching select must not forward
    ex_valid = 1'b1; ex_op = OP_MTLO; ex_rs = 32'hCAFE_F00D; id_rd_sel = 1'b0;
    #1;
    n_checks++; if (id_rd_data !== 32'h1234_5678) $display("FAIL fwd_sel_mismatch: got %h required 12345678", id_rd_data); else n_pass++;
    id_rd_sel = 1'b1;
    #1;
    n_checks++; if (id_rd_data !== 32'hCAFE_F00D) $display("FAIL fwd_mtlo: got %h required cafef00d", id_rd_data); else n_pass++;
    tick();
    ex_valid = 1'b0; id_rd_req = 1'b0;
    n_checks++; if (lo_q !== 32'hCAFE_F00D) $display("FAIL mtlo_lo: got %h required cafef00d", lo_q); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL mtlo_done: got %b required 0", done); else n_pass++;
  endtask

  task automatic test_mult();
    int lat;
    issue(OP_MULT, 32'hFFFF_FFFE, 32'h3, 1'b1);
    id_rd_req = 1'b1; id_rd_sel = 1'b1;
    ex_valid = 1'b1; ex_op = OP_MTHI; ex_rs = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (busy !== 1'b1) $display("FAIL mult_busy: got %b required 1", busy); else n_pass++;
    n_checks++; if (stall_req !== 1'b1) $display("FAIL mult_stall: got %b required 1", stall_req); else n_pass++;
    wait_done(lat);
    ex_valid = 1'b0;
    #1;
    n_checks++; if (lat !== 2) $display("FAIL mult_latency: got %0d required 2", lat); else n_pass++;
    n_checks++; if (stall_req !== 1'b0) $display("FAIL mult_stall_release: got %b required 0", stall_req); else n_pass++;
    n_checks++; if (id_rd_data !== 32'hFFFF_FFFA) $display("FAIL mult_mflo: got %h required fffffffa", id_rd_data); else n_pass++;
    n_checks++; if (hi_q !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h required ffffffff", hi_q); else n_pass++;
    id_rd_req = 1'b0;
    tick();
    n_checks++; if (done !== 1'b0) $display("FAIL mult_done_width: got %b required 0", done); else n_pass++;
  endtask

  task automatic test_div();
    int lat;
    issue(OP_DIV, -32'sd7, 32'd2, 1'b1);
    wait_done(lat);
    n_checks++; if (lat !== 32) $display("FAIL div_latency: got %0d required 32", lat); else n_pass++;
    n_checks++; if (lo_q !== 32'hFFFF_FFFD || hi_q !== 32'hFFFF_FFFF) $display("FAIL div_neg7_2: got %h_%h required ffffffff_fffffffd", hi_q, lo_q); else n_pass++;
    tick();
    issue(OP_DIVU, 32'd7, 32'd0, 1'b1);
    n_checks++; if (busy !== 1'b1) $display("FAIL divz_busy: got %b required 1", busy); else n_pass++;
    wait_done(lat);
    n_checks++; if (lat !== 1) $display("FAIL divz_latency: got %0d required 1", lat); else n_pass++;
    n_checks++; if (hi_q !== 32'd7 || lo_q !== 32'hFFFF_FFFF) $display("FAIL divz_result: got %h_%h required 00000007_ffffffff", hi_q, lo_q); else n_pass++;
    tick();
  endtask

  task automatic test_flush();
    int lat;
    bit seen;
    issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
    for (int i = 1; i < 10; i++) tick();
    ex_flush = 1'b1;
    tick();
    ex_flush = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL flush_busy: got %b required 0", busy); else n_pass++;
    n_checks++; if (hi_q !== 32'd7 || lo_q !== 32'hFFFF_FFFF) $display("FAIL flush_hilo: got %h_%h required 00000007_ffffffff", hi_q, lo_q); else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen = 1'b1;
      tick();
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL flush_no_done: got done=%b required 0", seen); else n_pass++;
    // Flush together with a valid op: nothing is accepted
    ex_valid = 1'b1; ex_op = OP_MTHI; ex_rs = 32'h55; ex_flush = 1'b1;
    tick();
    ex_valid = 1'b0; ex_flush = 1'b0;
    n_checks++; if (hi_q !== 32'd7) $display("FAIL flush_with_valid: got %h required 00000007", hi_q); else n_pass++;
    issue(OP_MULTU, 32'd5, 32'd6, 1'b1);
    wait_done(lat);
    n_checks++; if (lat !== 2) $display("FAIL multu_latency: got %0d required 2", lat); else n_pass++;
    n_checks++; if (lo_q !== 32'd30 || hi_q !== 32'd0) $display("FAIL multu_5x6: got %h_%h required 00000000_0000001e", hi_q, lo_q); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done(lat);
    n_checks++; if (busy !== 1'b0) $display("FAIL b2b_idle: got %b required 0", busy); else n_pass++;
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd10, 1'b1);
    n_checks++; if (busy !== 1'b1) $display("FAIL b2b_accept: got %b required 1", busy); else n_pass++;
    wait_done(lat);
    n_checks++; if (lat !== 32) $display("FAIL b2b_div_latency: got %0d required 32", lat); else n_pass++;
    tick();
  endtask

  task automatic test_corners();
    int lat;
    logic [2:0]  ops [4];
    logic [31:0] as  [4];
    logic [31:0] bs  [4];
    ops = '{OP_DIV, OP_DIV, OP_DIVU, OP_MULT};
    as  = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    bs  = '{32'hFFFF_FFFF, 32'd3, 32'd1, 32'h8000_0000};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], 1'b1);
      wait_done(lat);
      n_checks++; if (lat !== exp_lat(ops[i], bs[i])) $display("FAIL corner%0d_latency: got %0d required %0d", i, lat, exp_lat(ops[i], bs[i])); else n_pass++;
      if (i == 0) begin
        n_checks++; if (lo_q !== 32'h8000_0000 || hi_q !== 32'h0) $display("FAIL min_div_m1: got %h_%h required 00000000_80000000", hi_q, lo_q); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_random();
    int lat;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if (i % 4 == 0) b = 32'h0;
      if (i % 3 == 1) b = 32'($urandom_range(1, 9));
      if (i % 5 == 2) a = -a;
      issue(op, a, b, 1'b1);
      wait_done(lat);
      n_checks++; if (lat !== exp_lat(op, b)) $display("FAIL rand%0d_latency: got %0d required %0d", i, lat, exp_lat(op, b)); else n_pass++;
    end
    tick();
  endtask

  task automatic test_reset_mid_div();
    bit seen;
    issue(OP_DIV, 32'd1000, 32'd3, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    n_checks++; if (hi_q !== 32'h0 || lo_q !== 32'h0) $display("FAIL rst_mid_hilo: got %h_%h required 0_0", hi_q, lo_q); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b required 0", busy); else n_pass++;
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen = 1'b1;
      tick();
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL rst_mid_no_done: got done=%b required 0", seen); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mtxx_forward();
    test_mult();
    test_div();
    test_flush();
    test_back_to_back();
    test_corners();
    test_random();
    test_reset_mid_div();
    tick();
    n_checks++; if (scoreboard.size() != 0) $display("FAIL sb_leftover: got %0d pending required 0", scoreboard.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Successor to the HI/LO forwarding select logic.
- Owns the architectural HI/LO registers and a multi-cycle multiply/divide engine.
- Forwards in-flight MTHI/MTLO writes to decode-stage MFHI/MFLO reads.
- Raises a pipeline stall while a result is pending. Sits beside the EX stage; ID reads through it and EX issues into it.

Parameters:
- WIDTH, 32, data width of operands, HI and LO.
- MUL_LAT, 2, cycles from multiply acceptance to HI/LO commit (≥1).
- CNT_W, $clog2(WIDTH+1), derived divider iteration counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX holds a HI/LO-writing op.
- ex_op  in  3  op code from hilo_pkg: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- ex_rs  in  WIDTH  operand A / MTHI-MTLO data.
- ex_rt  in  WIDTH  operand B.
- ex_flush  in  1  kill EX op and any in-flight op.
- id_rd_req  in  1  ID holds MFHI/MFLO.
- id_rd_sel  in  1  0=HI, 1=LO.
- id_rd_data  out  WIDTH  forwarded HI/LO value.
- busy  out  1  engine occupied.
- stall_req  out  1  freeze ID/EX this cycle.
- done  out  1  one-cycle pulse after a mul/div commit.
- hi_q  out  WIDTH  architectural HI.
- lo_q  out  WIDTH  architectural LO.

Behaviour:
- Reset (async, rst_n=0): hi_q=0, lo_q=0, state=IDLE, busy=0, done=0, counter=0.
- States: IDLE, MUL, DIV.
- Accept condition: ex_valid & ~busy & ~ex_flush. Ops requested while busy are not accepted; stall_req holds EX.

MTHI/MTLO:
- Accepted in IDLE only; write hi_q/lo_q at the next edge.
- State stays IDLE; busy stays 0.

MULT/MULTU:
- Product is formed at acceptance: 2·WIDTH bits, signed or unsigned per op.
- Product is delayed through a MUL_LAT-deep register chain.
- IDLE→MUL. busy=1 for MUL_LAT cycles.
- HI/LO = product upper/lower half, committed at edge t0+MUL_LAT; state→IDLE at that edge.

DIV/DIVU:
- Radix-2 restoring division, one quotient bit per cycle. IDLE→DIV. busy=1 for WIDTH cycles; commit at edge t0+WIDTH.
- LO=quotient, truncated toward zero. HI=remainder, sign of dividend.
- Signed ops: operands are converted to magnitude at acceptance and sign-fixed at commit.
- Divisor=0: commit at t0+1 with HI=ex_rs, LO=all-ones.
- Signed MIN/−1: LO=MIN, HI=0, full latency.

done:
- Registered; high for exactly the one cycle after a mul/div commit.
- Not asserted for MTHI/MTLO.

stall_req:
- (ex_valid & busy) | (id_rd_req & busy).
- MFHI/MFLO never read a stale value while an op is pending.

id_rd_data forwarding priority:
- (1) EX MTHI/MTLO being accepted this cycle with matching sel → ex_rs.
- (2) otherwise hi_q/lo_q.
- Combinational; valid only when stall_req=0.

ex_flush:
- Returns the engine to IDLE at the next edge. HI/LO unchanged; no done pulse.
- Flush in the commit cycle wins: no commit.
- Flush with ex_valid: op not accepted.

Other rules:
- Back-to-back ops: a new op is accepted in the first cycle busy=0, i.e. the cycle after the commit edge.
- Reset mid-operation: all state cleared immediately; the pending result is lost.

Decomposition:
- hilo_pkg: op encodings (OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3, OP_MTHI=4, OP_MTLO=5), state enum, WIDTH default.
- Sub-module radix2_divider: unsigned WIDTH-bit iterative core. Ports: start, dividend, divisor, kill, quotient, remainder, valid. It has the same clock and async active-low reset.
- Sign handling and the multiplier pipeline stay in the top module.

Test Plan:
- Reset, then ID MFHI/MFLO → id_rd_data=0, stall_req=0, busy=0.
- MTHI 0x1234_5678 in EX with same-cycle ID MFHI → id_rd_data=0x1234_5678 via forwarding; hi_q=0x1234_5678 after the edge.
- MULT rs=0xFFFF_FFFE (−2), rt=3 → busy for 2 cycles, then HI=0xFFFF_FFFF, LO=0xFFFF_FFFA. done pulses once. An ID MFLO issued meanwhile stalls until then.
- DIV rs=−7, rt=2 → 32 busy cycles, then LO=0xFFFF_FFFD (−3), HI=0xFFFF_FFFF (−1). DIVU 7/0 → commits after 1 cycle with HI=7, LO=0xFFFF_FFFF.
- DIVU 100/7 with ex_flush asserted at busy cycle 10 → IDLE next cycle; HI/LO keep prior values; no done. A following MULTU 5×6 gives LO=30, HI=0.
- Assert rst_n=0 mid-DIV → hi_q=lo_q=0, busy=0 immediately. Also: signed MIN/−1 → LO=0x8000_0000, HI=0.
